// File: rtl/a25_wb_pkg.sv
// Shared load-size encodings and the write-back entry layout for the default
// 32-bit data / 11-bit tag configuration.
package a25_wb_pkg;

   localparam logic [1:0] LS_BYTE = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_WORD = 2'b10;

   typedef struct packed {
      logic [31:0] data;
      logic [10:0] rd;
   } wb_entry_t;

endpackage

// File: rtl/a25_wb_load_buffer_if.sv
// Memory-stage push side and register-file pop side of the load buffer.
// The slave modport is the buffer's view; master is the surrounding pipeline.
interface a25_wb_load_buffer_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_W   = 11,
   parameter int unsigned DEPTH  = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic              i_mem_stall;
   logic [DATA_W-1:0] i_mem_read_data;
   logic              i_mem_read_data_valid;
   logic [RD_W-1:0]   i_mem_load_rd;
   logic [31:0]       i_daddress;
   logic [1:0]        i_load_size;
   logic              i_load_signed;
   logic              o_mem_ready;
   logic              i_wb_ready;
   logic [DATA_W-1:0] o_wb_read_data;
   logic              o_wb_read_data_valid;
   logic [RD_W-1:0]   o_wb_load_rd;
   logic              o_full;
   logic              o_empty;
   logic [CNT_W-1:0]  o_count;
   logic              o_overflow;

   modport slave (
      input  i_mem_stall, i_mem_read_data, i_mem_read_data_valid, i_mem_load_rd,
      input  i_daddress, i_load_size, i_load_signed, i_wb_ready,
      output o_mem_ready, o_wb_read_data, o_wb_read_data_valid, o_wb_load_rd,
      output o_full, o_empty, o_count, o_overflow
   );

   modport master (
      output i_mem_stall, i_mem_read_data, i_mem_read_data_valid, i_mem_load_rd,
      output i_daddress, i_load_size, i_load_signed, i_wb_ready,
      input  o_mem_ready, o_wb_read_data, o_wb_read_data_valid, o_wb_load_rd,
      input  o_full, o_empty, o_count, o_overflow
   );

endinterface

// File: rtl/a25_load_align.sv
// Combinational load aligner: byte/halfword extract with sign or zero
// extension, and ARM-style rotate for unaligned word loads.
module a25_load_align
   import a25_wb_pkg::*;
(
   input  logic [31:0] data_i,
   input  logic [1:0]  addr_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   output logic [31:0] data_o
);

   logic [31:0] rotated;
   logic [15:0] half;

   always_comb begin
      // Low word of the doubled value shifted right is a rotate right by 8*addr.
      rotated = 32'({data_i, data_i} >> {addr_i, 3'b000});
      half    = addr_i[1] ? data_i[31:16] : data_i[15:0];
      case (size_i)
         LS_BYTE: data_o = {{24{signed_i & rotated[7]}}, rotated[7:0]};
         LS_HALF: data_o = {{16{signed_i & half[15]}}, half};
         default: data_o = rotated;  // word and the reserved encoding
      endcase
   end

endmodule

// File: rtl/a25_wb_load_buffer.sv
// DEPTH-entry load-result FIFO between the memory stage and the register-file
// write port, with optional alignment of load data before it is stored.
module a25_wb_load_buffer #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned RD_W     = 11,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ALIGN_EN = 1
) (
   input logic                 i_clk,
   input logic                 i_rst,
   a25_wb_load_buffer_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [RD_W-1:0]   rd;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;

   logic              push_req, push_ok, pop, full, empty;
   logic [DATA_W-1:0] push_data;
   entry_t            head;

   logic unused_addr;
   assign unused_addr = ^bus.i_daddress[31:2];

   if (ALIGN_EN != 0) begin : g_align
      a25_load_align u_align (
         .data_i   (bus.i_mem_read_data),
         .addr_i   (bus.i_daddress[1:0]),
         .size_i   (bus.i_load_size),
         .signed_i (bus.i_load_signed),
         .data_o   (push_data)
      );
   end else begin : g_bypass
      logic unused_align;
      assign unused_align = ^{bus.i_load_size, bus.i_load_signed, bus.i_daddress[1:0]};
      assign push_data    = bus.i_mem_read_data;
   end

   always_comb begin
      full     = (count_q == CNT_W'(DEPTH));
      empty    = (count_q == '0);
      push_req = bus.i_mem_read_data_valid & ~bus.i_mem_stall;
      pop      = ~empty & bus.i_wb_ready;
      // A full buffer still takes a push when the head leaves in the same cycle.
      push_ok  = push_req & (~full | pop);

      for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = mem_q[i];
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = '{data: push_data, rd: bus.i_mem_load_rd};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
      overflow_d = overflow_q | (push_req & full & ~pop);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign head                     = mem_q[rd_ptr_q];
   assign bus.o_wb_read_data       = empty ? '0 : head.data;
   assign bus.o_wb_load_rd         = empty ? '0 : head.rd;
   assign bus.o_wb_read_data_valid = ~empty;
   assign bus.o_mem_ready          = ~full;
   assign bus.o_full               = full;
   assign bus.o_empty              = empty;
   assign bus.o_count              = count_q;
   assign bus.o_overflow           = overflow_q;

endmodule
